// File: rtl/imem_loader.sv
// imem_loader: programs the instruction memory from a length-prefixed
// little-endian byte stream and holds the core in reset while loading.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds a 32-bit sum trailer).
module imem_loader #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err_size,
    output logic        err_csum,
    output logic        cpu_hold
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        word_buf_q, word_buf_d;
    logic [IDX_W-1:0]   word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic               mem_we_d;
    logic [31:0]        mem_addr_d, mem_wdata_d;
    logic               done_d, err_size_d, cpu_hold_d, active_d;
    logic               accept, word_last;
    logic [31:0]        full_word;
    state_t             after_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]        sum_q, sum_d;
    logic               err_csum_q, err_csum_d;
    assign err_csum   = err_csum_q;
    assign after_data = CSUM;
`else
    assign err_csum   = 1'b0;
    assign after_data = DONE;
`endif

    assign accept    = in_valid && in_ready;
    assign word_last = (byte_cnt_q == 2'd3);
    assign full_word = {in_data, word_buf_q};

    // Next-state, word assembly and registered-output next values
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_buf_d  = word_buf_q;
        word_cnt_d  = word_cnt_q;
        word_idx_d  = word_idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        done_d      = done;
        err_size_d  = err_size;
        cpu_hold_d  = cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        err_csum_d  = err_csum_q;
`endif

        // Bytes shift in from the top so three bytes leave {b2,b1,b0}
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_buf_d = {in_data, word_buf_q[23:8]};
        end

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
                if (start) begin
                    state_d    = HDR;
                    byte_cnt_d = 2'd0;
                    word_idx_d = '0;
                    err_size_d = 1'b0;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = 32'd0;
                    err_csum_d = 1'b0;
`endif
                end
            end
            HDR: begin
                if (accept && word_last) begin
                    if (full_word > 32'(MEM_DEPTH)) begin
                        err_size_d = 1'b1;
                        state_d    = DONE;
                    end else if (full_word == 32'd0) begin
                        state_d    = after_data;
                    end else begin
                        word_cnt_d = IDX_W'(full_word);
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && word_last) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
                    mem_wdata_d = full_word;
                    word_idx_d  = word_idx_q + IDX_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + full_word;
`endif
                    if (word_idx_q == word_cnt_q - IDX_W'(1))
                        state_d = after_data;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept && word_last) begin
                    err_csum_d = (full_word != sum_q);
                    state_d    = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        active_d = (state_d == HDR) || (state_d == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_d == CSUM)
`endif
                   ;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            word_buf_q <= 24'd0;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            done       <= 1'b0;
            err_size   <= 1'b0;
            cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
            err_csum_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_buf_q <= word_buf_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
            in_ready   <= active_d;
            busy       <= active_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            done       <= done_d;
            err_size   <= err_size_d;
            cpu_hold   <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_csum_q <= err_csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0x0 and 0x100) share stimulus;
// writes are collected per instance and compared with a stream-level model.
module tb_imem_loader;

    typedef logic [63:0] wq_t[$];
    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] dq_t[$];

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h0;

    logic in_ready0, mem_we0, busy0, done0, err_size0, err_csum0, cpu_hold0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic in_ready1, mem_we1, busy1, done1, err_size1, err_csum1, cpu_hold1;
    logic [31:0] mem_addr1, mem_wdata1;

    int n_checks = 0;
    int n_fails  = 0;
    wq_t wq0, wq1;

    always #5 clk = ~clk;

    imem_loader #(.MEM_DEPTH(1024), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .busy(busy0), .done(done0), .err_size(err_size0), .err_csum(err_csum0), .cpu_hold(cpu_hold0));

    imem_loader #(.MEM_DEPTH(1024), .BASE_ADDR(32'h100)) dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .done(done1), .err_size(err_size1), .err_csum(err_csum1), .cpu_hold(cpu_hold1));

    // Collect every write strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we0) wq0.push_back({mem_addr0, mem_wdata0});
        if (mem_we1) wq1.push_back({mem_addr1, mem_wdata1});
    end

    // Model: byte stream for a program (header, words, optional sum trailer)
    function automatic bq_t build_stream(input dq_t w, input bit bad);
        bq_t s;
        logic [31:0] n, sum;
        n = 32'(w.size());
        sum = 32'd0;
        for (int i = 0; i < 4; i++) s.push_back(8'(n >> (8 * i)));
        foreach (w[k]) begin
            sum = sum + w[k];
            for (int i = 0; i < 4; i++) s.push_back(8'(w[k] >> (8 * i)));
        end
        sum = sum + (bad ? 32'd1 : 32'd0);
        if (CSUM_EN)
            for (int i = 0; i < 4; i++) s.push_back(8'(sum >> (8 * i)));
        return s;
    endfunction

    // Model: expected (address, data) write list
    function automatic wq_t exp_writes(input logic [31:0] base, input dq_t w);
        wq_t q;
        foreach (w[k]) q.push_back({base + 32'(k) * 32'd4, w[k]});
        return q;
    endfunction

    task automatic do_start();
        @(negedge clk);
        wq0.delete();
        wq1.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: continuous, 1: one idle cycle per byte, 2: random idles
    task automatic send_bytes(input bq_t s, input int mode);
        foreach (s[i]) begin
            int idle, to;
            bit sent;
            idle = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (idle) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            sent = 1'b0;
            to = 0;
            while (!sent) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = s[i];
                if (in_ready0) sent = 1'b1;
                else if (++to > 50) begin
                    n_checks++; n_fails++;
                    $display("FAIL send_timeout: byte %0d never accepted, in_ready=%b required 1", i, in_ready0);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done0 && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (!done0) begin
            n_checks++; n_fails++;
            $display("FAIL done_timeout: done=%b required 1", done0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready0, mem_we0, busy0, done0, err_size0, err_csum0, cpu_hold0, mem_addr0, mem_wdata0}
            !== {6'b0, 1'b1, 64'h0}) begin
            n_fails++;
            $display("FAIL reset_values: rdy=%b we=%b busy=%b done=%b es=%b ec=%b hold=%b addr=%h data=%h required 0/0/0/0/0/0/1/0/0",
                     in_ready0, mem_we0, busy0, done0, err_size0, err_csum0, cpu_hold0, mem_addr0, mem_wdata0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cpu_hold0, busy0, in_ready0} !== 3'b100) begin
            n_fails++;
            $display("FAIL idle_hold: hold/busy/rdy=%b%b%b required 100", cpu_hold0, busy0, in_ready0);
        end
    endtask

    task automatic test_basic(input int mode);
        dq_t w;
        wq_t e;
        w = '{32'h00100513, 32'h00200593};
        e = exp_writes(32'h0, w);
        do_start();
        n_checks++;
        if ({busy0, in_ready0, done0} !== 3'b110) begin
            n_fails++;
            $display("FAIL start_latency m%0d: busy/rdy/done=%b%b%b required 110", mode, busy0, in_ready0, done0);
        end
        send_bytes(build_stream(w, 1'b0), mode);
        wait_done();
        n_checks++;
        if (wq0.size() != e.size()) begin
            n_fails++;
            $display("FAIL basic_count m%0d: writes=%0d required %0d", mode, wq0.size(), e.size());
        end else foreach (e[k]) begin
            n_checks++;
            if (wq0[k] !== e[k]) begin
                n_fails++;
                $display("FAIL basic_write m%0d[%0d]: got %h required %h", mode, k, wq0[k], e[k]);
            end
        end
        n_checks++;
        if ({done0, cpu_hold0, busy0, err_size0, err_csum0} !== 5'b10000) begin
            n_fails++;
            $display("FAIL basic_status m%0d: done/hold/busy/es/ec=%b%b%b%b%b required 10000",
                     mode, done0, cpu_hold0, busy0, err_size0, err_csum0);
        end
    endtask

    task automatic test_size_error();
        bq_t s;
        s = '{8'h01, 8'h04, 8'h00, 8'h00};
        do_start();
        send_bytes(s, 0);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h13;
            n_checks++;
            if (in_ready0 !== 1'b0) begin
                n_fails++;
                $display("FAIL size_excess_ready: in_ready=%b required 0", in_ready0);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({wq0.size() == 0, err_size0, done0, busy0} !== 4'b1110) begin
            n_fails++;
            $display("FAIL size_error: writes=%0d es=%b done=%b busy=%b required 0/1/1/0",
                     wq0.size(), err_size0, done0, busy0);
        end
    endtask

    task automatic test_reset_mid();
        dq_t w;
        bq_t s;
        wq_t e;
        w = '{$urandom, $urandom};
        s = build_stream(w, 1'b0);
        do_start();
        send_bytes(s[0:8], 0);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready0, mem_we0, busy0, done0, err_size0, err_csum0, cpu_hold0, mem_addr0, mem_wdata0}
            !== {6'b0, 1'b1, 64'h0}) begin
            n_fails++;
            $display("FAIL midreset_values: rdy=%b we=%b busy=%b done=%b es=%b ec=%b hold=%b addr=%h data=%h required 0/0/0/0/0/0/1/0/0",
                     in_ready0, mem_we0, busy0, done0, err_size0, err_csum0, cpu_hold0, mem_addr0, mem_wdata0);
        end
        n_checks++;
        if (wq0.size() != 1 || wq0[0] !== {32'h0, w[0]}) begin
            n_fails++;
            $display("FAIL midreset_partial: writes=%0d first=%h required 1 write %h",
                     wq0.size(), (wq0.size() > 0) ? wq0[0] : 64'h0, {32'h0, w[0]});
        end
        reset = 1'b0;
        w = '{$urandom};
        e = exp_writes(32'h0, w);
        do_start();
        send_bytes(build_stream(w, 1'b0), 2);
        wait_done();
        n_checks++;
        if (wq0.size() != 1 || wq0[0] !== e[0] || err_size0 !== 1'b0) begin
            n_fails++;
            $display("FAIL midreset_reload: writes=%0d first=%h es=%b required 1 write %h es=0",
                     wq0.size(), (wq0.size() > 0) ? wq0[0] : 64'h0, err_size0, e[0]);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        dq_t w;
        w = '{32'h1, 32'h2};
        for (int bad = 0; bad < 2; bad++) begin
            do_start();
            send_bytes(build_stream(w, bad[0]), 0);
            wait_done();
            n_checks++;
            if (err_csum0 !== bad[0] || wq0.size() != 2) begin
                n_fails++;
                $display("FAIL csum_%0d: err_csum=%b writes=%0d required %b and 2", bad, err_csum0, wq0.size(), bad[0]);
            end
        end
    endtask
`endif

    task automatic test_base_addr();
        dq_t w;
        bq_t s;
        wq_t e;
        w = '{$urandom, $urandom, $urandom};
        s = build_stream(w, 1'b0);
        e = exp_writes(32'h100, w);
        do_start();
        send_bytes(s[0:5], 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_bytes(s[6:$], 0);
        wait_done();
        n_checks++;
        if (wq1.size() != 3) begin
            n_fails++;
            $display("FAIL base_count: writes=%0d required 3", wq1.size());
        end else foreach (e[k]) begin
            n_checks++;
            if (wq1[k] !== e[k]) begin
                n_fails++;
                $display("FAIL base_write[%0d]: got %h required %h", k, wq1[k], e[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            dq_t w;
            wq_t e0, e1;
            bit bad;
            int n;
            n = int'($urandom_range(0, 5));
            for (int k = 0; k < n; k++) w.push_back($urandom);
            bad = CSUM_EN && ($urandom_range(0, 1) == 1);
            e0 = exp_writes(32'h0, w);
            e1 = exp_writes(32'h100, w);
            do_start();
            send_bytes(build_stream(w, bad), int'($urandom_range(0, 2)));
            wait_done();
            n_checks++;
            if (wq0 != e0 || wq1 != e1) begin
                n_fails++;
                $display("FAIL random_writes it%0d: n=%0d got %0d/%0d writes required %0d", it, n, wq0.size(), wq1.size(), n);
            end
            n_checks++;
            if ({err_size0, err_csum0, cpu_hold0, done1} !== {1'b0, bad, 1'b0, 1'b1}) begin
                n_fails++;
                $display("FAIL random_status it%0d: es=%b ec=%b hold=%b done1=%b required 0/%b/0/1",
                         it, err_size0, err_csum0, cpu_hold0, done1, bad);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic(0);
        test_basic(1);
        test_size_error();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_base_addr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
